line_draw_engine: RTL and testbench

Command-driven Bresenham line rasteriser sitting directly upstream of the VGA framebuffer controller. The CPU loads endpoints and a 3-bit colour through a small register window, issues a command, and the block emits one (x, y, colour) plot request per cycle on a valid/ready write port. The framebuffer controller consumes that port and writes its 160x120 3-bit framebuffer, so the 6502 no longer hand-plots every pixel.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/line_stepper.sv | 109 ++++++++++
 rtl/line_draw_engine.sv | 135 +++++++++++++
 tb/tb_line_draw_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer path.
//   - default framebuffer geometry (160x120, 3-bit colour)
//   - register window addresses used by line_draw_engine
//   - command codes accepted on the CMD register
//   - line_draw_engine FSM state encoding
package vga_pkg;

  localparam int unsigned FB_W_DEFAULT = 160;
  localparam int unsigned FB_H_DEFAULT = 120;

  localparam logic [2:0] REG_X0    = 3'd0;
  localparam logic [2:0] REG_Y0    = 3'd1;
  localparam logic [2:0] REG_X1    = 3'd2;
  localparam logic [2:0] REG_Y1    = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_CMD   = 3'd5;

  localparam logic [7:0] CMD_LINE = 8'h01;
  localparam logic [7:0] CMD_PLOT = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EMIT
  } state_e;

endpackage

// File: rtl/line_stepper.sv
// Bresenham stepping datapath for line_draw_engine.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load              capture endpoints and initialise dx/dy/err/cur
//   advance           take one Bresenham step from cur
//   x0, y0, x1, y1    start and end point (sampled on load)
//   cur_x, cur_y      current point
//   done              cur equals the end point
module line_stepper (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  output logic [7:0] cur_x,
  output logic [7:0] cur_y,
  output logic       done
);

  logic [7:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]         end_x_q, end_x_d, end_y_q, end_y_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [8:0]  dx_q, dx_d, dy_q, dy_d;
  logic signed [10:0] err_q, err_d;

  logic [7:0]         adx, ady;
  logic signed [8:0]  dx_n, dy_n;
  logic signed [10:0] dx_n11, dy_n11, dx11, dy11, add_x, add_y;
  logic signed [11:0] e2, dx12, dy12;
  logic               step_x, step_y;

  always_comb begin
    adx    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    dx_n   = $signed({1'b0, adx});
    dy_n   = 9'sd0 - $signed({1'b0, ady});
    dx_n11 = {{2{dx_n[8]}}, dx_n};
    dy_n11 = {{2{dy_n[8]}}, dy_n};

    // Both step decisions look at the pre-update err.
    e2     = {err_q, 1'b0};
    dx12   = {{3{dx_q[8]}}, dx_q};
    dy12   = {{3{dy_q[8]}}, dy_q};
    dx11   = {{2{dx_q[8]}}, dx_q};
    dy11   = {{2{dy_q[8]}}, dy_q};
    step_x = (e2 >= dy12);
    step_y = (e2 <= dx12);
    add_x  = step_x ? dy11 : '0;
    add_y  = step_y ? dx11 : '0;

    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;

    if (load) begin
      cur_x_d  = x0;
      cur_y_d  = y0;
      end_x_d  = x1;
      end_y_d  = y1;
      sx_neg_d = (x1 < x0);
      sy_neg_d = (y1 < y0);
      dx_d     = dx_n;
      dy_d     = dy_n;
      err_d    = dx_n11 + dy_n11;
    end else if (advance) begin
      err_d = err_q + add_x + add_y;
      if (step_x) cur_x_d = sx_neg_q ? (cur_x_q - 8'd1) : (cur_x_q + 8'd1);
      if (step_y) cur_y_d = sy_neg_q ? (cur_y_q - 8'd1) : (cur_y_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
    end else begin
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      end_x_q  <= end_x_d;
      end_y_q  <= end_y_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
    end
  end

  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign done  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

endmodule

// File: rtl/line_draw_engine.sv
// Command-driven Bresenham line rasteriser feeding the framebuffer controller.
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   WE, ADDR, DATA      register window (X0,Y0,X1,Y1,COLOR,CMD)
//   BUSY                a command is executing
//   PX_VALID/PX_READY   plot request handshake
//   PX_X, PX_Y, PX_COLOR plot request payload
// Build option: LINE_CLIP_EN suppresses points outside FB_W x FB_H while the
// stepper keeps walking through them.
module line_draw_engine
  import vga_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEFAULT,
  parameter int unsigned FB_H = FB_H_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WE,
  input  logic [2:0] ADDR,
  input  logic [7:0] DATA,
  output logic       BUSY,
  output logic       PX_VALID,
  input  logic       PX_READY,
  output logic [7:0] PX_X,
  output logic [7:0] PX_Y,
  output logic [2:0] PX_COLOR
);

  state_e     state_q, state_d;
  logic [7:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [2:0] color_q, color_d, px_color_q, px_color_d;
  logic       plot_q, plot_d;

  logic       cmd_go, load, advance, step, done, on_screen, show;
  logic [7:0] cur_x, cur_y;

  line_stepper u_stepper (
    .clk     (CLK),
    .rst     (RST),
    .load    (load),
    .advance (advance),
    .x0      (x0_q),
    .y0      (y0_q),
    .x1      (plot_q ? x0_q : x1_q),
    .y1      (plot_q ? y0_q : y1_q),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .done    (done)
  );

  assign on_screen = (32'(cur_x) < FB_W) && (32'(cur_y) < FB_H);

`ifdef LINE_CLIP_EN
  assign show = on_screen;
`else
  assign show = 1'b1;
  logic unused_clip;
  assign unused_clip = on_screen;
`endif

  always_comb begin
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    if (WE) begin
      case (ADDR)
        REG_X0:    x0_d    = DATA;
        REG_Y0:    y0_d    = DATA;
        REG_X1:    x1_d    = DATA;
        REG_Y1:    y1_d    = DATA;
        REG_COLOR: color_d = DATA[2:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    cmd_go = WE && (ADDR == REG_CMD) && (state_q == IDLE) &&
             ((DATA == CMD_LINE) || (DATA == CMD_PLOT));
    // Off-screen points are walked through without waiting for a handshake.
    step       = (state_q == EMIT) && (PX_READY || !show);
    load       = (state_q == SETUP);
    advance    = step && !done;
    state_d    = state_q;
    plot_d     = plot_q;
    px_color_d = px_color_q;
    case (state_q)
      IDLE: begin
        if (cmd_go) begin
          state_d = SETUP;
          plot_d  = (DATA == CMD_PLOT);
        end
      end
      SETUP: begin
        state_d    = EMIT;
        px_color_d = color_q;
      end
      EMIT: begin
        if (step && done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      px_color_q <= '0;
      plot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      px_color_q <= px_color_d;
      plot_q     <= plot_d;
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign PX_VALID = (state_q == EMIT) && show;
  assign PX_X     = cur_x;
  assign PX_Y     = cur_y;
  assign PX_COLOR = px_color_q;

endmodule

// File: tb/tb_line_draw_engine.sv
module tb_line_draw_engine;
  import vga_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WE = 1'b0;
  logic [2:0] ADDR = '0;
  logic [7:0] DATA = '0;
  logic       BUSY, PX_VALID;
  logic       PX_READY = 1'b1;
  logic [7:0] PX_X, PX_Y;
  logic [2:0] PX_COLOR;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [18:0] hold_val = '0;

  line_draw_engine #(.FB_W(160), .FB_H(120)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .DATA(DATA),
    .BUSY(BUSY), .PX_VALID(PX_VALID), .PX_READY(PX_READY),
    .PX_X(PX_X), .PX_Y(PX_Y), .PX_COLOR(PX_COLOR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int c);
    exp_q.push_back({8'(x), 8'(y), 3'(c)});
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    WE = 1'b1; ADDR = a; DATA = d;
    @(posedge CLK); #1;
    WE = 1'b0;
  endtask

  task automatic set_line(input int x0, input int y0, input int x1, input int y1, input int c);
    wr(REG_X0, 8'(x0));
    wr(REG_Y0, 8'(y0));
    wr(REG_X1, 8'(x1));
    wr(REG_Y1, 8'(y1));
    wr(REG_COLOR, 8'(c));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSY && n < budget);
    chk(name, int'(BUSY), 0);
  endtask

  // Monitor / scoreboard: pops on every handshake, checks hold stability.
  always @(negedge CLK) begin
    logic [18:0] cur, e;
    cur = {PX_X, PX_Y, PX_COLOR};
    if (hold_v) begin
      checks++;
      if (!PX_VALID || cur != hold_val) begin
        errors++;
        $display("FAIL hold_stable got v=%0d %h expected v=1 %h", PX_VALID, cur, hold_val);
      end
    end
    hold_v   = PX_VALID && !PX_READY;
    hold_val = cur;
    if (PX_VALID && PX_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_point got (%0d,%0d,%0d) expected none", PX_X, PX_Y, PX_COLOR);
      end else begin
        e = exp_q.pop_front();
        if (cur != e) begin
          errors++;
          $display("FAIL point got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   PX_X, PX_Y, PX_COLOR, e[18:11], e[10:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_valid", int'(PX_VALID), 0);
    chk("rst_xyc", int'({PX_X, PX_Y, PX_COLOR}), 0);

    // Single plot: latency and BUSY width
    wr(REG_X0, 8'd10);
    wr(REG_Y0, 8'd20);
    wr(REG_COLOR, 8'd5);
    push(10, 20, 5);
    wr(REG_CMD, CMD_PLOT);
    @(negedge CLK);
    chk("plot_setup_busy", int'(BUSY), 1);
    chk("plot_setup_valid", int'(PX_VALID), 0);
    @(negedge CLK);
    chk("plot_emit_valid", int'(PX_VALID), 1);
    chk("plot_emit_busy", int'(BUSY), 1);
    @(negedge CLK);
    chk("plot_done_busy", int'(BUSY), 0);
    chk("plot_done_valid", int'(PX_VALID), 0);

    // Horizontal, one point per cycle
    set_line(0, 0, 3, 0, 3);
    for (int i = 0; i < 4; i++) push(i, 0, 3);
    wr(REG_CMD, CMD_LINE);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("horiz_valid", int'(PX_VALID), 1);
    end
    @(negedge CLK);
    chk("horiz_idle", int'(BUSY), 0);

    // Steep
    set_line(0, 0, 1, 3, 6);
    push(0, 0, 6); push(0, 1, 6); push(1, 2, 6); push(1, 3, 6);
    wr(REG_CMD, CMD_LINE);
    wait_idle("steep_idle", 50);
    chk("steep_drained", exp_q.size(), 0);

    // Reverse diagonal
    set_line(5, 5, 2, 2, 1);
    push(5, 5, 1); push(4, 4, 1); push(3, 3, 1); push(2, 2, 1);
    wr(REG_CMD, CMD_LINE);
    wait_idle("rev_idle", 50);
    chk("rev_drained", exp_q.size(), 0);

    // Backpressure on the horizontal line
    set_line(0, 0, 3, 0, 7);
    for (int i = 0; i < 4; i++) push(i, 0, 7);
    wr(REG_CMD, CMD_LINE);
    for (int i = 0; i < 100; i++) begin
      if (!BUSY) break;
      PX_READY = pat[i % 4];
      @(posedge CLK); #1;
    end
    PX_READY = 1'b1;
    wait_idle("bp_idle", 50);
    chk("bp_drained", exp_q.size(), 0);

    // Right-edge clip: BUSY spans SETUP plus four steps either way
    set_line(158, 0, 161, 0, 2);
    push(158, 0, 2); push(159, 0, 2);
`ifndef LINE_CLIP_EN
    push(160, 0, 2); push(161, 0, 2);
`endif
    wr(REG_CMD, CMD_LINE);
    @(negedge CLK);
    chk("clip_setup_busy", int'(BUSY), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("clip_step_busy", int'(BUSY), 1);
    end
    @(negedge CLK);
    chk("clip_done_busy", int'(BUSY), 0);
    chk("clip_drained", exp_q.size(), 0);

    // CMD write while busy is ignored; register write only affects next command
    set_line(0, 0, 3, 0, 2);
    for (int i = 0; i < 4; i++) push(i, 0, 2);
    wr(REG_CMD, CMD_LINE);
    wr(REG_CMD, CMD_PLOT);
    wr(REG_X0, 8'd7);
    wait_idle("ign_idle", 50);
    repeat (3) @(negedge CLK);
    chk("ign_no_extra_cmd", int'(BUSY), 0);
    chk("ign_drained", exp_q.size(), 0);
    push(7, 0, 2);
    wr(REG_CMD, CMD_PLOT);
    wait_idle("ign_plot_idle", 50);

    // Reset mid-line
    set_line(0, 0, 3, 0, 4);
    push(0, 0, 4); push(1, 0, 4); push(2, 0, 4);
    wr(REG_CMD, CMD_LINE);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_valid", int'(PX_VALID), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_xyc", int'({PX_X, PX_Y, PX_COLOR}), 0);
    repeat (3) @(negedge CLK);
    chk("midrst_quiet", int'(PX_VALID), 0);
    chk("midrst_drained", exp_q.size(), 0);
    // Registers cleared: a plot now lands on (0,0) colour 0
    push(0, 0, 0);
    wr(REG_CMD, CMD_PLOT);
    wait_idle("midrst_plot_idle", 50);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
